// File: rtl/chroni_mem_arbiter_if.sv
// Bus bundle between the arbiter, its two requesters (video, CPU) and the memory.
interface chroni_mem_arbiter_if #(
  parameter int unsigned ADDR_W = 13,
  parameter int unsigned DATA_W = 8
);
  // video fetcher port
  logic [ADDR_W-1:0] vid_addr;
  logic              vid_req;
  logic              vid_ack;
  logic [DATA_W-1:0] vid_data;
  // CPU port
  logic [ADDR_W-1:0] cpu_addr;
  logic              cpu_we;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_req;
  logic              cpu_ack;
  logic [DATA_W-1:0] cpu_rdata;
  // memory port
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_rd;
  logic              mem_wr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  // arbiter side
  modport slave (
    input  vid_addr, vid_req, cpu_addr, cpu_we, cpu_wdata, cpu_req, mem_rdata,
    output vid_ack, vid_data, cpu_ack, cpu_rdata, mem_addr, mem_rd, mem_wr, mem_wdata
  );

  // requester / memory side
  modport master (
    output vid_addr, vid_req, cpu_addr, cpu_we, cpu_wdata, cpu_req, mem_rdata,
    input  vid_ack, vid_data, cpu_ack, cpu_rdata, mem_addr, mem_rd, mem_wr, mem_wdata
  );
endinterface

// File: rtl/chroni_mem_arbiter.sv
// Single-port memory arbiter: chroni video fetcher (fixed priority) and CPU.
// A streak limit hands the slot to a waiting CPU after VIDEO_BURST_MAX video
// grants in a row. One access in flight; service period is 4+MEM_LATENCY.
module chroni_mem_arbiter #(
  parameter int unsigned ADDR_W          = 13,
  parameter int unsigned DATA_W          = 8,
  parameter int unsigned MEM_LATENCY     = 1,
  parameter int unsigned VIDEO_BURST_MAX = 16
) (
  input  logic                sys_clk,
  input  logic                reset_n,
  chroni_mem_arbiter_if.slave bus
);

  localparam int unsigned CNT_W    = 3;
  localparam int unsigned STREAK_W = 8;
  localparam logic [CNT_W-1:0]    LAST_WAIT  = CNT_W'(MEM_LATENCY - 1);
  localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(VIDEO_BURST_MAX);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ISSUE   = 3'd1,
    S_WAIT    = 3'd2,
    S_ACK     = 3'd3,
    S_RELEASE = 3'd4
  } state_t;

  typedef enum logic {
    OWN_VID = 1'b0,
    OWN_CPU = 1'b1
  } owner_t;

  state_t              r_state,     w_state;
  owner_t              r_owner,     w_owner;
  logic                r_we,        w_we;
  logic [CNT_W-1:0]    r_cnt,       w_cnt;
  logic [STREAK_W-1:0] r_streak,    w_streak;
  logic [ADDR_W-1:0]   r_mem_addr,  w_mem_addr;
  logic [DATA_W-1:0]   r_mem_wdata, w_mem_wdata;
  logic                r_mem_rd,    w_mem_rd;
  logic                r_mem_wr,    w_mem_wr;
  logic                r_vid_ack,   w_vid_ack;
  logic                r_cpu_ack,   w_cpu_ack;
  logic [DATA_W-1:0]   r_vid_data,  w_vid_data;
  logic [DATA_W-1:0]   r_cpu_rdata, w_cpu_rdata;
  logic                w_grant_cpu;

  // CPU wins if video is idle or video has used up its streak allowance
  assign w_grant_cpu = bus.cpu_req && (!bus.vid_req || (r_streak == STREAK_MAX));

  // Next-state and next-output logic for the access sequencer
  always_comb begin
    w_state     = r_state;
    w_owner     = r_owner;
    w_we        = r_we;
    w_cnt       = r_cnt;
    w_streak    = r_streak;
    w_mem_addr  = r_mem_addr;
    w_mem_wdata = r_mem_wdata;
    w_mem_rd    = 1'b0;
    w_mem_wr    = 1'b0;
    w_vid_ack   = 1'b0;
    w_cpu_ack   = 1'b0;
    w_vid_data  = r_vid_data;
    w_cpu_rdata = r_cpu_rdata;

    case (r_state)
      S_IDLE: begin
        if (bus.vid_req || bus.cpu_req) begin
          w_state = S_ISSUE;
          if (w_grant_cpu) begin
            w_owner     = OWN_CPU;
            w_we        = bus.cpu_we;
            w_mem_addr  = bus.cpu_addr;
            w_mem_wdata = bus.cpu_wdata;
            w_mem_rd    = !bus.cpu_we;
            w_mem_wr    = bus.cpu_we;
            w_streak    = '0;
          end else begin
            w_owner    = OWN_VID;
            w_we       = 1'b0;
            w_mem_addr = bus.vid_addr;
            w_mem_rd   = 1'b1;
            // streak only grows while the CPU is actually being held off
            if (!bus.cpu_req) begin
              w_streak = '0;
            end else if (r_streak != STREAK_MAX) begin
              w_streak = r_streak + STREAK_W'(1);
            end
          end
        end
      end
      S_ISSUE: begin
        w_state = S_WAIT;
        w_cnt   = '0;
      end
      S_WAIT: begin
        if (r_cnt == LAST_WAIT) begin
          w_state = S_ACK;
          if (r_owner == OWN_VID) begin
            w_vid_ack  = 1'b1;
            w_vid_data = bus.mem_rdata;
          end else begin
            w_cpu_ack = 1'b1;
            if (!r_we) begin
              w_cpu_rdata = bus.mem_rdata;
            end
          end
        end else begin
          w_cnt = r_cnt + CNT_W'(1);
        end
      end
      S_ACK: begin
        w_state = S_RELEASE;
      end
      S_RELEASE: begin
        w_state = S_IDLE;
      end
      default: begin
        w_state = S_IDLE;
      end
    endcase
  end

  // State and output registers; reset abandons any access in flight
  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= S_IDLE;
      r_owner     <= OWN_VID;
      r_we        <= 1'b0;
      r_cnt       <= '0;
      r_streak    <= '0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_mem_rd    <= 1'b0;
      r_mem_wr    <= 1'b0;
      r_vid_ack   <= 1'b0;
      r_cpu_ack   <= 1'b0;
      r_vid_data  <= '0;
      r_cpu_rdata <= '0;
    end else begin
      r_state     <= w_state;
      r_owner     <= w_owner;
      r_we        <= w_we;
      r_cnt       <= w_cnt;
      r_streak    <= w_streak;
      r_mem_addr  <= w_mem_addr;
      r_mem_wdata <= w_mem_wdata;
      r_mem_rd    <= w_mem_rd;
      r_mem_wr    <= w_mem_wr;
      r_vid_ack   <= w_vid_ack;
      r_cpu_ack   <= w_cpu_ack;
      r_vid_data  <= w_vid_data;
      r_cpu_rdata <= w_cpu_rdata;
    end
  end

  assign bus.mem_addr  = r_mem_addr;
  assign bus.mem_wdata = r_mem_wdata;
  assign bus.mem_rd    = r_mem_rd;
  assign bus.mem_wr    = r_mem_wr;
  assign bus.vid_ack   = r_vid_ack;
  assign bus.cpu_ack   = r_cpu_ack;
  assign bus.vid_data  = r_vid_data;
  assign bus.cpu_rdata = r_cpu_rdata;

endmodule
